// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
//   Shared definitions for the data-RAM access arbiter: default geometry,
//   FSM state encoding and requester (grant) identifiers.
//   Build option: ARB_ROUND_ROBIN_EN (consumed by rr_arb2) selects round-robin
//   arbitration; undefined gives fixed priority with m0 winning.
// ----------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // Transaction FSM: IDLE -> ACCESS -> RESP -> IDLE
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    // Requester identifiers, also used as the last-grant pointer value
    typedef logic gnt_id_t;
    localparam gnt_id_t GNT_M0 = 1'b0;
    localparam gnt_id_t GNT_M1 = 1'b1;

    // One-hot grant vector to requester id (m0 when nothing is granted)
    function automatic gnt_id_t onehot_to_id(input logic [1:0] gnt);
        return gnt[1] ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-way arbiter producing a one-hot grant from a 2-bit request vector.
//   Build option ARB_ROUND_ROBIN_EN:
//     defined   - on contention, grant the requester not granted last; the
//                 last-grant pointer updates only when a grant is accepted and
//                 resets to m1 so that m0 is favoured first.
//     undefined - fixed priority, m0 wins on contention; no pointer state.
//   A lone requester is granted in both builds.
// Ports
//   clk     in  1  rising-edge clock
//   rst     in  1  synchronous, active-high reset
//   req     in  2  request vector {m1, m0}
//   accept  in  1  the current grant is being taken this cycle
//   gnt     out 2  one-hot grant {m1, m0}; 0 when no request
// ----------------------------------------------------------------------------
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN

    gnt_id_t last_q;
    gnt_id_t last_d;

    always_comb begin
        if (req == 2'b11) begin
            gnt = (last_q == GNT_M0) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        last_d = last_q;
        if (accept) begin
            last_d = onehot_to_id(gnt);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_M1;
        end else begin
            last_q <= last_d;
        end
    end

`else

    // Fixed priority: m0 whenever it asks, otherwise whatever m1 asks
    always_comb begin
        gnt = req[0] ? 2'b01 : req;
    end

    // Clock, reset and accept only feed the pointer, which this build omits
    logic unused_ok;
    assign unused_ok = ^{clk, rst, accept};

`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// ----------------------------------------------------------------------------
// ram_access_arbiter
//   Shares one single-port RAM (registered, write-first read data) between
//   two requesters, m0 (CPU load/store) and m1 (program/debug loader).
//   One transaction at a time: accept in IDLE, drive the RAM for one cycle in
//   ACCESS, present the response in RESP until the winner consumes it.
//   Accept at cycle N gives rsp_valid at N+2; minimum 3 cycles per access.
//   Build option: ARB_ROUND_ROBIN_EN (round-robin vs. fixed m0 priority),
//   implemented inside rr_arb2.
// Ports (mX = m0 or m1)
//   clk, rst          clock; synchronous active-high reset
//   mX_req_valid/ready  request handshake; ready pulses for the accept cycle
//   mX_req_we/addr/wdata  request fields, held by requester until accepted
//   mX_rsp_valid/ready  response handshake; valid held until ready
//   mX_rsp_rdata        read data (new word for writes); 0 outside RESP
//   ram_we/addr/din     RAM control; we is high only in ACCESS
//   ram_dout            RAM read data, valid one cycle after the address
// ----------------------------------------------------------------------------
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [DATA_W-1:0] m0_rsp_rdata,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [DATA_W-1:0] m1_rsp_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t              state_q,  state_d;
    gnt_id_t             gnt_id_q, gnt_id_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                accept;
    logic                winner_rsp_ready;

    assign req = {m1_req_valid, m0_req_valid};

    // No acceptance while reset is held: the latch would be discarded at the
    // edge and the requester would wrongly believe it had been taken.
    assign accept = (state_q == ST_IDLE) && (req != 2'b00) && !rst;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign winner_rsp_ready = (gnt_id_q == GNT_M1) ? m1_rsp_ready : m0_rsp_ready;

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_ACCESS;
                    gnt_id_d = onehot_to_id(gnt);
                    if (gnt[1]) begin
                        we_d    = m1_req_we;
                        addr_d  = m1_req_addr;
                        wdata_d = m1_req_wdata;
                    end else begin
                        we_d    = m0_req_we;
                        addr_d  = m0_req_addr;
                        wdata_d = m0_req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (winner_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= GNT_M0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Request side
    assign m0_req_ready = accept && gnt[0];
    assign m1_req_ready = accept && gnt[1];

    // Response side: addr is held through RESP, so ram_dout stays stable
    assign m0_rsp_valid = (state_q == ST_RESP) && (gnt_id_q == GNT_M0);
    assign m1_rsp_valid = (state_q == ST_RESP) && (gnt_id_q == GNT_M1);
    assign m0_rsp_rdata = m0_rsp_valid ? ram_dout : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? ram_dout : '0;

    // RAM side. ram_we is deliberately not gated by rst: the RAM has no reset
    // and a write in ACCESS lands at that edge even if reset is asserted.
    assign ram_we   = (state_q == ST_ACCESS) && we_q;
    assign ram_addr = addr_q;
    assign ram_din  = wdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_access_arbiter
//   Directed self-checking bench for ram_access_arbiter with a behavioural
//   1024x32 registered write-first RAM. Expected values are hand-computed.
//   Honours ARB_ROUND_ROBIN_EN for the contention expectations.
// ----------------------------------------------------------------------------
module tb_ram_access_arbiter;

    logic        clk;
    logic        rst;

    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_ready;
    logic [9:0]  m0_req_addr;
    logic [31:0] m0_req_wdata, m0_rsp_rdata;

    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_ready;
    logic [9:0]  m1_req_addr;
    logic [31:0] m1_req_wdata, m1_rsp_rdata;

    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ram_access_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_rdata (m1_rsp_rdata),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    // Behavioural single-port RAM: registered output, write-first, no reset
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= ram_din;
        end else begin
            ram_dout      <= mem[ram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic we,
                           input logic [9:0] a, input logic [31:0] d);
        if (port == 0) begin
            m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
        end else begin
            m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
        end
    endtask

    function automatic logic get_ready(input int port);
        return (port == 0) ? m0_req_ready : m1_req_ready;
    endfunction

    function automatic logic get_rsp_valid(input int port);
        return (port == 0) ? m0_rsp_valid : m1_rsp_valid;
    endfunction

    function automatic logic [31:0] get_rdata(input int port);
        return (port == 0) ? m0_rsp_rdata : m1_rsp_rdata;
    endfunction

    // Sample at falling edges until the port's req_ready shows; bounded.
    task automatic wait_ready(input int port, input string tag, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (get_ready(port)) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
        end
        check({tag, "_accept"}, ok, 1'b1);
    endtask

    // One full transaction on a port; returns at the falling edge in RESP.
    task automatic txn(input int port, input logic we, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] exp,
                       input string tag, output int acc);
        tick();
        set_req(port, 1'b1, we, a, d);
        wait_ready(port, tag, acc);
        check({tag, "_idle_we"}, ram_we, 1'b0);
        tick();
        set_req(port, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        check({tag, "_access_we"}, ram_we, we);
        check({tag, "_access_addr"}, ram_addr, a);
        if (we) check({tag, "_access_din"}, ram_din, d);
        check({tag, "_access_rspv"}, get_rsp_valid(port), 1'b0);
        @(negedge clk);
        check({tag, "_resp_rspv"}, get_rsp_valid(port), 1'b1);
        check({tag, "_resp_rdata"}, get_rdata(port), exp);
        check({tag, "_resp_we"}, ram_we, 1'b0);
        check({tag, "_other_rspv"}, get_rsp_valid(1 - port), 1'b0);
    endtask

    // Both ports read in the same IDLE cycle: m0 at 0x000, m1 at 0x001.
    task automatic contend(input int first, input string tag);
        int          second;
        int          acc;
        logic [31:0] exp_first, exp_second;
        second     = 1 - first;
        exp_first  = (first == 0)  ? 32'h1111_0000 : 32'h2222_0001;
        exp_second = (second == 0) ? 32'h1111_0000 : 32'h2222_0001;
        tick();
        set_req(0, 1'b1, 1'b0, 10'h000, 32'h0);
        set_req(1, 1'b1, 1'b0, 10'h001, 32'h0);
        @(negedge clk);
        check({tag, "_grant"}, {m1_req_ready, m0_req_ready}, (first == 0) ? 2'b01 : 2'b10);
        tick();
        set_req(first, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        check({tag, "_loser_rdy_access"}, get_ready(second), 1'b0);
        @(negedge clk);
        check({tag, "_win_rspv"}, get_rsp_valid(first), 1'b1);
        check({tag, "_win_rdata"}, get_rdata(first), exp_first);
        check({tag, "_loser_rspv"}, get_rsp_valid(second), 1'b0);
        check({tag, "_loser_rdy_resp"}, get_ready(second), 1'b0);
        wait_ready(second, {tag, "_second"}, acc);
        tick();
        set_req(second, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_second_rspv"}, get_rsp_valid(second), 1'b1);
        check({tag, "_second_rdata"}, get_rdata(second), exp_second);
        check({tag, "_first_rspv_after"}, get_rsp_valid(first), 1'b0);
    endtask

    initial begin
        int acc, a0, a1, a2;

        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: every output at its reset value
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle_outputs_%0d", i),
                  {ram_we, ram_addr, ram_din, m0_req_ready, m1_req_ready,
                   m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata}, '0);
        end

        // m0 write then read of 0x005
        txn(0, 1'b1, 10'h005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "t1_wr", acc);
        txn(0, 1'b0, 10'h005, 32'h0, 32'hDEAD_BEEF, "t1_rd", acc);
        tick();
        @(negedge clk);
        check("t1_after_idle", {ram_we, m0_rsp_valid, m0_rsp_rdata}, '0);
        check("t1_addr_held", ram_addr, 10'h005);

        // Preload words used by the contention and back-to-back tests
        txn(1, 1'b1, 10'h000, 32'h1111_0000, 32'h1111_0000, "pre0", acc);
        txn(1, 1'b1, 10'h001, 32'h2222_0001, 32'h2222_0001, "pre1", acc);
        txn(1, 1'b1, 10'h002, 32'h3333_0002, 32'h3333_0002, "pre2", acc);

        // Contention: pointer last granted m1, so m0 first in both builds
        contend(0, "t2a");
        // Lone m0 access moves the pointer to m0
        txn(0, 1'b0, 10'h002, 32'h0, 32'h3333_0002, "t2_solo", acc);
`ifdef ARB_ROUND_ROBIN_EN
        contend(1, "t2b");
`else
        contend(0, "t2b");
`endif

        // Back-to-back m0 reads: accepts exactly 3 cycles apart
        txn(0, 1'b0, 10'h000, 32'h0, 32'h1111_0000, "t5_0", a0);
        txn(0, 1'b0, 10'h001, 32'h0, 32'h2222_0001, "t5_1", a1);
        txn(0, 1'b0, 10'h002, 32'h0, 32'h3333_0002, "t5_2", a2);
        check("t5_gap01", a1 - a0, 3);
        check("t5_gap12", a2 - a1, 3);

        // m1 write with a stalled response while m0 waits
        tick();
        m1_rsp_ready = 1'b0;
        set_req(1, 1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
        wait_ready(1, "t3", acc);
        tick();
        set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
        set_req(0, 1'b1, 1'b0, 10'h005, 32'h0);
        @(negedge clk);
        check("t3_access_we", ram_we, 1'b1);
        check("t3_m0_blocked_access", m0_req_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t3_hold%0d_rspv", i), m1_rsp_valid, 1'b1);
            check($sformatf("t3_hold%0d_rdata", i), m1_rsp_rdata, 32'h1234_5678);
            check($sformatf("t3_hold%0d_m0_rdy", i), m0_req_ready, 1'b0);
        end
        tick();
        m1_rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_release_rspv", m1_rsp_valid, 1'b1);
        wait_ready(0, "t3_m0", acc);
        tick();
        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("t3_m0_rdata", m0_rsp_rdata, 32'hDEAD_BEEF);
        check("t3_m1_rspv_after", m1_rsp_valid, 1'b0);

        // Reset during ACCESS of an m0 read drops the transaction
        tick();
        set_req(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
        wait_ready(0, "t4", acc);
        tick();
        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        set_req(1, 1'b1, 1'b0, 10'h003, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rdy_in_reset", {m1_req_ready, m0_req_ready}, 2'b00);
        check("t4_rspv_in_reset", m0_rsp_valid, 1'b0);
        tick();
        rst = 1'b0;
        set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4_post_reset_%0d", i),
                  {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                   ram_we, ram_addr, m0_rsp_rdata}, '0);
        end
        txn(0, 1'b0, 10'h3FF, 32'h0, 32'h1234_5678, "t4_reissue", acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
